// File: rtl/mem_arbiter.sv
// Two-port round-robin block arbiter in front of one memory; grant in IDLE, command from the next cycle, one DONE cycle after memory done.
// Losing port sees busywait until served; memory command is held until done or watchdog expiry.
module mem_arbiter #(
    parameter int BLOCK_SIZE   = 2,
    parameter int LINE_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int TIMEOUT      = 255,
    localparam int AW = ADDRESS_SIZE - BLOCK_SIZE - 2,
    localparam int DW = (2 ** BLOCK_SIZE) * LINE_SIZE
) (
    input  logic          clk_i,
    input  logic          reset_i,

    input  logic          p0_read_i,
    input  logic          p0_wr_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wr_data_i,
    output logic          p0_busywait_o,
    output logic [DW-1:0] p0_read_data_o,
    output logic          p0_read_done_o,
    output logic          p0_write_done_o,

    input  logic          p1_read_i,
    input  logic          p1_wr_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wr_data_i,
    output logic          p1_busywait_o,
    output logic [DW-1:0] p1_read_data_o,
    output logic          p1_read_done_o,
    output logic          p1_write_done_o,

    output logic          m_read_o,
    output logic          m_wr_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wr_data_o,
    input  logic          m_busywait_i,
    input  logic [DW-1:0] m_read_data_i,
    input  logic          m_read_done_i,
    input  logic          m_write_done_i,

    output logic          timeout_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;

    logic          r_owner;
    logic          r_last;
    logic          r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [7:0]    r_wdog;
    logic          r_to;
    logic          r_err;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_req0;
    logic          w_req1;
    logic          w_grant;
    logic          w_gnt_port;
    logic          w_done_ok;
    logic          w_tmo;
    logic          w_cmd;
    logic          w_done_st;
    logic          w_unused;

    // Memory busy is advisory only; sequencing relies on done pulses and the watchdog.
    assign w_unused   = m_busywait_i;

    assign w_req0     = p0_read_i | p0_wr_i;
    assign w_req1     = p1_read_i | p1_wr_i;
    assign w_gnt_port = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_grant    = (r_state == S_IDLE) & (w_req0 | w_req1);
    assign w_done_ok  = r_op ? m_write_done_i : m_read_done_i;
    assign w_tmo      = (r_state == S_WAIT) & ~w_done_ok & (r_wdog == TO_LAST);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req0 | w_req1) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_done_ok | (r_wdog == TO_LAST)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_op     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wdog   <= 8'd0;
            r_to     <= 1'b0;
            r_err    <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_gnt_port;
                r_last  <= w_gnt_port;
                // Write wins when a port raises read and write together.
                r_op    <= w_gnt_port ? p1_wr_i : p0_wr_i;
                r_addr  <= w_gnt_port ? p1_addr_i : p0_addr_i;
                r_wdata <= w_gnt_port ? p1_wr_data_i : p0_wr_data_i;
                r_wdog  <= 8'd0;
                r_to    <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + 8'd1;
                if (w_done_ok && !r_op) begin
                    if (r_owner) begin
                        r_rdata1 <= m_read_data_i;
                    end else begin
                        r_rdata0 <= m_read_data_i;
                    end
                end
                if (w_tmo) begin
                    r_to  <= 1'b1;
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Command is decoded from state so reset removes it without waiting for a clock.
    assign w_cmd     = (r_state == S_ISSUE) | (r_state == S_WAIT);
    assign w_done_st = (r_state == S_DONE);

    assign m_read_o       = w_cmd & ~r_op;
    assign m_wr_o         = w_cmd & r_op;
    assign m_addr_o       = r_addr;
    assign m_wr_data_o    = r_wdata;

    assign p0_read_data_o  = r_rdata0;
    assign p1_read_data_o  = r_rdata1;
    assign p0_read_done_o  = w_done_st & ~r_owner & ~r_op & ~r_to;
    assign p0_write_done_o = w_done_st & ~r_owner & r_op & ~r_to;
    assign p1_read_done_o  = w_done_st & r_owner & ~r_op & ~r_to;
    assign p1_write_done_o = w_done_st & r_owner & r_op & ~r_to;

    assign p0_busywait_o   = w_req0 & ~(w_done_st & ~r_owner);
    assign p1_busywait_o   = w_req1 & ~(w_done_st & r_owner);

    assign timeout_err_o   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, scoreboard of expected port completions, vector table plus corner sequences.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          p0_read_i, p0_wr_i, p1_read_i, p1_wr_i;
    logic [AW-1:0] p0_addr_i, p1_addr_i;
    logic [DW-1:0] p0_wr_data_i, p1_wr_data_i;
    logic          p0_busywait_o, p0_read_done_o, p0_write_done_o;
    logic          p1_busywait_o, p1_read_done_o, p1_write_done_o;
    logic [DW-1:0] p0_read_data_o, p1_read_data_o;
    logic          m_read_o, m_wr_o;
    logic [AW-1:0] m_addr_o;
    logic [DW-1:0] m_wr_data_o;
    logic          m_busywait_i, m_read_done_i, m_write_done_i;
    logic [DW-1:0] m_read_data_i;
    logic          timeout_err_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .p0_read_i(p0_read_i), .p0_wr_i(p0_wr_i), .p0_addr_i(p0_addr_i), .p0_wr_data_i(p0_wr_data_i),
        .p0_busywait_o(p0_busywait_o), .p0_read_data_o(p0_read_data_o),
        .p0_read_done_o(p0_read_done_o), .p0_write_done_o(p0_write_done_o),
        .p1_read_i(p1_read_i), .p1_wr_i(p1_wr_i), .p1_addr_i(p1_addr_i), .p1_wr_data_i(p1_wr_data_i),
        .p1_busywait_o(p1_busywait_o), .p1_read_data_o(p1_read_data_o),
        .p1_read_done_o(p1_read_done_o), .p1_write_done_o(p1_write_done_o),
        .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_addr_o(m_addr_o), .m_wr_data_o(m_wr_data_o),
        .m_busywait_i(m_busywait_i), .m_read_data_i(m_read_data_i),
        .m_read_done_i(m_read_done_i), .m_write_done_i(m_write_done_i),
        .timeout_err_o(timeout_err_o)
    );

    typedef struct {
        int          port;
        logic        wr;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        int           port;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic         exp_wr;
        logic [127:0] exp_data;
    } vec_t;

    exp_t         sb_q[$];
    logic [127:0] mem[16];
    int           mem_lat    = 3;
    bit           mem_silent = 1'b0;
    int           n_assert   = 0;
    int           n_fail     = 0;

    function automatic logic [127:0] pat(input int a);
        return {32'hB000_0000 + 32'(a), 32'hC0DE_0000 + 32'(a),
                32'h1234_5600 + 32'(a), 32'hFACE_0000 + 32'(a)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [27:0] a, input logic [127:0] d);
        if (p == 0) begin
            p0_read_i = rd; p0_wr_i = wr; p0_addr_i = a; p0_wr_data_i = d;
        end else begin
            p1_read_i = rd; p1_wr_i = wr; p1_addr_i = a; p1_wr_data_i = d;
        end
    endtask

    function automatic logic done_of(input int p);
        return (p == 0) ? (p0_read_done_o | p0_write_done_o) : (p1_read_done_o | p1_write_done_o);
    endfunction

    function automatic logic busy_of(input int p);
        return (p == 0) ? p0_busywait_o : p1_busywait_o;
    endfunction

    // Call #1 after a rising edge. Holds the request until the port's done, dropping it in the DONE cycle.
    task automatic port_txn(input int p, input logic rd, input logic wr, input logic [27:0] a,
                            input logic [127:0] d, input bit solo);
        bit got     = 1'b0;
        bit busy_ok = 1'b1;
        int cyc     = 0;
        set_port(p, rd, wr, a, d);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_i);
            cyc++;
            if (solo && cyc == 2) begin
                check("issue_cmd", {m_wr_o, m_read_o}, wr ? 2'b10 : 2'b01);
                check("issue_addr", m_addr_o, a);
                if (wr) check("issue_wdata", m_wr_data_o, d);
            end
            if (done_of(p)) begin
                got = 1'b1;
                if (busy_of(p) !== 1'b0) busy_ok = 1'b0;
                set_port(p, 1'b0, 1'b0, a, d);
            end else if (busy_of(p) !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        check($sformatf("txn_done_p%0d", p), got, 1'b1);
        check($sformatf("busy_profile_p%0d", p), busy_ok, 1'b1);
        if (solo) check("latency", cyc, mem_lat + 2);
    endtask

    // Memory model: answers after mem_lat command cycles unless silenced.
    initial begin : mem_model
        int cnt = 0;
        bit responded = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            m_read_done_i  = 1'b0;
            m_write_done_i = 1'b0;
            if (!(m_read_o || m_wr_o)) begin
                cnt = 0; responded = 1'b0; m_busywait_i = 1'b0;
            end else if (!responded && !mem_silent) begin
                cnt++;
                m_busywait_i = 1'b1;
                if (cnt >= mem_lat) begin
                    responded = 1'b1;
                    m_busywait_i = 1'b0;
                    if (m_wr_o) begin
                        mem[m_addr_o[3:0]] = m_wr_data_o;
                        m_write_done_i = 1'b1;
                    end else begin
                        m_read_data_i = mem[m_addr_o[3:0]];
                        m_read_done_i = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard: every port completion must match the oldest expectation.
    initial begin : sb_monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            for (int p = 0; p < 2; p++) begin
                if (done_of(p)) begin
                    if (sb_q.size() == 0) begin
                        n_assert++;
                        n_fail++;
                        $display("FAIL unexpected_done: port %0d completed with nothing expected", p);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_port", p, e.port);
                        check("sb_op", (p == 0) ? p0_write_done_o : p1_write_done_o, e.wr);
                        if (!e.wr) check("sb_data", (p == 0) ? p0_read_data_o : p1_read_data_o, e.data);
                    end
                end
            end
        end
    end

    initial begin : main
        vec_t         tbl[6];
        logic [127:0] other;
        logic [127:0] old_data;
        bit           got;
        bit           addr_ok;
        int           cmd_cnt;

        tbl[0] = '{0, 1'b1, 1'b0, 28'h3, 128'h0, 1'b0, pat(3)};
        tbl[1] = '{1, 1'b1, 1'b1, 28'h6, 128'h3, 1'b1, 128'h3};
        tbl[2] = '{1, 1'b1, 1'b0, 28'h6, 128'h0, 1'b0, 128'h3};
        tbl[3] = '{0, 1'b0, 1'b1, 28'h9, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA, 1'b1,
                   128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA};
        tbl[4] = '{0, 1'b1, 1'b0, 28'h9, 128'h0, 1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA};
        tbl[5] = '{1, 1'b1, 1'b0, 28'h2, 128'h0, 1'b0, pat(2)};

        for (int i = 0; i < 16; i++) mem[i] = pat(i);
        reset_i = 1'b0;
        set_port(0, 1'b1, 1'b0, 28'h0, 128'h0);
        set_port(1, 1'b0, 1'b0, 28'h0, 128'h0);
        m_busywait_i = 1'b0; m_read_done_i = 1'b0; m_write_done_i = 1'b0; m_read_data_i = '0;

        #12;
        check("rst_p0_busy", p0_busywait_o, 1'b1);
        check("rst_p1_busy", p1_busywait_o, 1'b0);
        check("rst_cmd", {m_wr_o, m_read_o}, 2'b00);
        check("rst_dones", {p1_write_done_o, p1_read_done_o, p0_write_done_o, p0_read_done_o}, 4'h0);
        check("rst_p0_data", p0_read_data_o, 128'h0);
        check("rst_p1_data", p1_read_data_o, 128'h0);
        check("rst_err", timeout_err_o, 1'b0);
        p0_read_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;

        // Tie after reset goes to port 0, then alternates.
        sb_q.push_back('{0, 1'b0, pat(1)});
        sb_q.push_back('{1, 1'b0, pat(2)});
        @(posedge clk_i); #1;
        fork
            port_txn(0, 1'b1, 1'b0, 28'h1, 128'h0, 1'b0);
            port_txn(1, 1'b1, 1'b0, 28'h2, 128'h0, 1'b0);
        join
        sb_q.push_back('{0, 1'b0, pat(11)});
        sb_q.push_back('{1, 1'b0, pat(12)});
        @(posedge clk_i); #1;
        fork
            port_txn(0, 1'b1, 1'b0, 28'hB, 128'h0, 1'b0);
            port_txn(1, 1'b1, 1'b0, 28'hC, 128'h0, 1'b0);
        join
        sb_q.push_back('{0, 1'b0, pat(13)});
        @(posedge clk_i); #1;
        port_txn(0, 1'b1, 1'b0, 28'hD, 128'h0, 1'b1);
        sb_q.push_back('{1, 1'b0, pat(14)});
        sb_q.push_back('{0, 1'b0, pat(15)});
        @(posedge clk_i); #1;
        fork
            port_txn(0, 1'b1, 1'b0, 28'hF, 128'h0, 1'b0);
            port_txn(1, 1'b1, 1'b0, 28'hE, 128'h0, 1'b0);
        join

        for (int i = 0; i < 6; i++) begin
            other = (tbl[i].port == 0) ? p1_read_data_o : p0_read_data_o;
            sb_q.push_back('{tbl[i].port, tbl[i].exp_wr, tbl[i].exp_data});
            @(posedge clk_i); #1;
            port_txn(tbl[i].port, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1);
            if (tbl[i].exp_wr) check("mem_written", mem[tbl[i].addr[3:0]], tbl[i].exp_data);
            check("other_port_data", (tbl[i].port == 0) ? p1_read_data_o : p0_read_data_o, other);
        end

        // Address and op change while in flight must not reach memory.
        mem_lat = 5;
        sb_q.push_back('{0, 1'b0, pat(7)});
        @(posedge clk_i); #1;
        set_port(0, 1'b1, 1'b0, 28'h7, 128'h0);
        got = 1'b0; addr_ok = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (i == 2) begin p0_addr_i = 28'h8; p0_wr_i = 1'b1; end
            if ((m_read_o || m_wr_o) && (m_addr_o !== 28'h7 || m_wr_o !== 1'b0)) addr_ok = 1'b0;
            if (p0_read_done_o) begin got = 1'b1; set_port(0, 1'b0, 1'b0, 28'h0, 128'h0); end
        end
        check("chg_done", got, 1'b1);
        check("chg_addr_held", addr_ok, 1'b1);
        mem_lat = 3;

        // Watchdog: silent memory, expiry after 8 WAIT cycles.
        mem_silent = 1'b1;
        old_data = p0_read_data_o;
        @(posedge clk_i); #1;
        set_port(0, 1'b1, 1'b0, 28'h5, 128'h0);
        got = 1'b0; cmd_cnt = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (m_read_o) cmd_cnt++;
            if (p0_busywait_o == 1'b0) begin
                got = 1'b1;
                check("tmo_no_done", p0_read_done_o, 1'b0);
                check("tmo_err", timeout_err_o, 1'b1);
                set_port(0, 1'b0, 1'b0, 28'h5, 128'h0);
            end
        end
        check("tmo_released", got, 1'b1);
        check("tmo_cmd_cycles", cmd_cnt, 9);
        check("tmo_data_kept", p0_read_data_o, old_data);
        mem_silent = 1'b0;
        sb_q.push_back('{0, 1'b0, pat(5)});
        @(posedge clk_i); #1;
        port_txn(0, 1'b1, 1'b0, 28'h5, 128'h0, 1'b1);
        check("tmo_err_sticky", timeout_err_o, 1'b1);

        // Reset in WAIT: command drops at once, request re-arbitrated afterwards.
        mem_silent = 1'b1;
        @(posedge clk_i); #1;
        set_port(1, 1'b1, 1'b0, 28'hA, 128'h0);
        repeat (4) @(negedge clk_i);
        check("pre_rst_cmd", m_read_o, 1'b1);
        reset_i = 1'b0;
        #1;
        check("rst_async_cmd", {m_wr_o, m_read_o}, 2'b00);
        check("rst_no_done", p1_read_done_o, 1'b0);
        check("rst_err_clr", timeout_err_o, 1'b0);
        check("rst_data_clr", p0_read_data_o, 128'h0);
        check("rst_p1_busy", p1_busywait_o, 1'b1);
        @(negedge clk_i);
        reset_i = 1'b1;
        mem_silent = 1'b0;
        sb_q.push_back('{1, 1'b0, pat(10)});
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (p1_read_done_o) begin got = 1'b1; set_port(1, 1'b0, 1'b0, 28'h0, 128'h0); end
        end
        check("rearb_done", got, 1'b1);

        repeat (3) @(negedge clk_i);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_SIZE, default 2, log2 of words per cache block.
REQ-002 Parameter LINE_SIZE, default 32, bits per word.
REQ-003 Parameter ADDRESS_SIZE, default 32, byte address width; block address width AW = ADDRESS_SIZE-BLOCK_SIZE-2 (28); block data width DW = 2**BLOCK_SIZE*LINE_SIZE (128).
REQ-004 Parameter TIMEOUT, default 255, maximum memory-owned cycles per transaction (8-bit counter).
REQ-005 clk_i  in  1  clock; all state updates on rising edge.
REQ-006 reset_i  in  1  reset, asynchronous, active-low.
REQ-007 p0_read_i / p0_wr_i  in  1 each  port 0 (instruction cache) block read / writeback request.
REQ-008 p0_addr_i  in  AW  port 0 block address; p0_wr_data_i  in  DW  port 0 writeback data.
REQ-009 p0_busywait_o  out  1; p0_read_data_o  out  DW; p0_read_done_o / p0_write_done_o  out  1 each.
REQ-010 p1_* ports identical to REQ-007..009 for port 1 (data cache).
REQ-011 m_read_o / m_wr_o  out  1 each; m_addr_o  out  AW; m_wr_data_o  out  DW  memory command side.
REQ-012 m_busywait_i  in  1; m_read_data_i  in  DW; m_read_done_i / m_write_done_i  in  1 each  memory response side.
REQ-013 timeout_err_o  out  1  sticky watchdog error flag.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, DONE; one owner register (0/1) and one last_grant register.
REQ-015 Port N is requesting when pN_read_i|pN_wr_i; pN_wr_i wins if both high (op latched as write).
REQ-016 IDLE: no request -> stay; one request -> grant it; both -> grant port != last_grant (round-robin); go to ISSUE.
REQ-017 At grant: latch owner, op, address and write data into internal registers; update last_grant; clear watchdog to 0.
REQ-018 ISSUE/WAIT: drive m_read_o or m_wr_o (latched op) high, m_addr_o/m_wr_data_o from latched registers; ISSUE lasts one cycle then WAIT.
REQ-019 WAIT: on m_read_done_i (read op) or m_write_done_i (write op) -> capture m_read_data_i (reads), drop m_read_o/m_wr_o, go to DONE; done of the wrong op type ignored.
REQ-020 DONE (exactly one cycle): owner's pN_read_done_o or pN_write_done_o high, owner's busywait low; then IDLE.
REQ-021 pN_read_data_o holds last data captured for port N until its next read completes.
REQ-022 pN_busywait_o = port N requesting AND NOT (state DONE AND owner==N); non-owner stays busy while the other is served.
REQ-023 Latency, uncontended read: request seen at edge 0 -> ISSUE edge 1 -> memory command visible cycle 1 onward -> done pulse from memory at edge k -> DONE after edge k+1.
REQ-024 Requester must drop request during DONE cycle; a request still high in IDLE is treated as new.
REQ-025 Request inputs changing after grant do not alter the in-flight transaction.
REQ-026 Watchdog increments each WAIT cycle; at TIMEOUT -> drop memory command, set timeout_err_o, go to DONE without done pulse (owner busywait low one cycle), data not updated.
REQ-027 timeout_err_o cleared only by reset.
REQ-028 m_busywait_i is informational only; arbiter never issues a new command before the previous done/timeout.

Reset
REQ-029 reset_i low: state IDLE, last_grant=1 (port 0 wins first tie), owner=0, watchdog=0, all done/command outputs 0, read data registers 0, timeout_err_o 0, busywaits reflect REQ-022.
REQ-030 Reset asserted mid-transaction aborts it immediately; memory command drops asynchronously; no done pulse issued.

Verification
REQ-031 Port 0 read addr 28'h3 alone -> m_read_o=1, m_addr_o=3 until read_done; p0_read_data_o = memory block, p0_read_done_o one cycle, p1 outputs untouched.
REQ-032 Both ports request reads same cycle after reset -> port 0 served first, p1_busywait_o high throughout; port 1 served next; then a new tie -> port 0 (alternation).
REQ-033 Port 1 write 128'h…0003 to addr 28'h6 with p1_read_i also high -> write issued only, p1_write_done_o pulses, memory block 6 updated.
REQ-034 Memory done never returned, TIMEOUT=8 -> command dropped after 8 WAIT cycles, timeout_err_o=1 and stays 1, FSM back to IDLE.
REQ-035 reset_i low during WAIT -> m_read_o/m_wr_o=0 immediately, no done pulse; after release, pending request re-arbitrated from IDLE.
REQ-036 Port 0 request changes address during WAIT -> m_addr_o keeps the latched address until completion.
